// File: rtl/imm_decode_queue_if.sv
// imm_decode_queue_if: instruction-in / decoded-immediate-out handshake bundle
interface imm_decode_queue_if #(parameter int XLEN = 32);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_ins;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm;
  logic [4:0]      out_fmt;
  logic [XLEN-1:0] out_target;
  logic            out_illegal;
  modport master (
    output flush, in_valid, in_ins, in_pc, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_target, out_illegal
  );
  modport slave (
    input  flush, in_valid, in_ins, in_pc, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_target, out_illegal
  );
endinterface

// File: rtl/imm_decode_queue.sv
// imm_decode_queue: RISC-V immediate/target decode feeding a small output FIFO
module imm_decode_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  imm_decode_queue_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [4:0]      fmt;
    logic [XLEN-1:0] target;
    logic            illegal;
  } entry_t;
  logic [6:0]      w_op;
  logic [31:0]     w_ins;
  logic            w_i, w_s, w_b, w_u, w_j, w_r, w_auipc;
  logic [31:0]     w_imm32;
  logic [XLEN-1:0] w_imm;
  entry_t          w_entry, w_head;
  logic            w_push, w_pop;
  entry_t          r_mem [DEPTH];
  logic [AW-1:0]   r_wp, r_rp;
  logic [AW:0]     r_cnt;
  assign w_ins   = bus.in_ins;
  assign w_op    = w_ins[6:0];
  assign w_i     = w_op == 7'h03 || w_op == 7'h0F || w_op == 7'h13 || w_op == 7'h67 ||
                   w_op == 7'h73 || (XLEN == 64 && w_op == 7'h1B);
  assign w_s     = w_op == 7'h23;
  assign w_b     = w_op == 7'h63;
  assign w_auipc = w_op == 7'h17;
  assign w_u     = w_auipc || w_op == 7'h37;
  assign w_j     = w_op == 7'h6F;
  assign w_r     = w_op == 7'h33 || (XLEN == 64 && w_op == 7'h3B);
  // every immediate is first formed at 32 bits, then sign-extended to XLEN
  assign w_imm32 = w_i ? {{20{w_ins[31]}}, w_ins[31:20]} :
                   w_s ? {{20{w_ins[31]}}, w_ins[31:25], w_ins[11:7]} :
                   w_b ? {{20{w_ins[31]}}, w_ins[7], w_ins[30:25], w_ins[11:8], 1'b0} :
                   w_u ? {w_ins[31:12], 12'h000} :
                   w_j ? {{12{w_ins[31]}}, w_ins[19:12], w_ins[20], w_ins[30:21], 1'b0} : 32'h0;
  assign w_imm   = XLEN'($signed(w_imm32));
  assign w_entry = '{
    imm:     w_imm,
    fmt:     {w_i, w_s, w_b, w_u, w_j},
    target:  (w_b || w_j || w_auipc) ? bus.in_pc + w_imm : '0,
    illegal: !(w_i || w_s || w_b || w_u || w_j || w_r)
  };
  assign bus.in_ready  = r_cnt != (AW+1)'(DEPTH);
  assign bus.out_valid = r_cnt != '0;
  assign w_push = bus.in_valid && bus.in_ready;
  assign w_pop  = bus.out_valid && bus.out_ready;
  assign w_head = r_mem[r_rp];
  assign bus.out_imm     = bus.out_valid ? w_head.imm : '0;
  assign bus.out_fmt     = bus.out_valid ? w_head.fmt : '0;
  assign bus.out_target  = bus.out_valid ? w_head.target : '0;
  assign bus.out_illegal = bus.out_valid && w_head.illegal;
  always_ff @(posedge clk) begin
    if (!rst_n || bus.flush) begin
      r_cnt <= '0;
      r_wp  <= '0;
      r_rp  <= '0;
    end else begin
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
      r_wp  <= w_push ? r_wp + 1'b1 : r_wp;
      r_rp  <= w_pop ? r_rp + 1'b1 : r_rp;
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= w_entry;
  end
endmodule

// File: doc/imm_decode_queue.md
# imm_decode_queue

Parametrised, pipelined immediate generator for the RISC-V decode path. It accepts one 32-bit instruction plus its PC per cycle over a valid/ready handshake, then decodes the format and sign-extends the immediate to XLEN. For branch, jump and AUIPC instructions it also computes the PC-relative target. Results are buffered in a small output FIFO so decode and the consumer are decoupled.

## Interface
- XLEN, 32: datapath width; legal values 32 or 64.
- DEPTH, 2: output FIFO entries; power of two, ≥2.

- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- flush  in  1  synchronously discard all buffered entries
- in_valid  in  1  instruction offered
- in_ready  out  1  queue can accept (count < DEPTH)
- in_ins  in  32  instruction word
- in_pc  in  XLEN  instruction address
- out_valid  out  1  head entry available
- out_ready  in  1  consumer takes head entry
- out_imm  out  XLEN  sign-extended immediate
- out_fmt  out  5  one-hot {I,S,B,U,J} = bits [4:0]; 0 for R-type and illegal
- out_target  out  XLEN  in_pc + imm for B, J, AUIPC; else 0
- out_illegal  out  1  opcode not recognised

## Operation
- Push when in_valid && in_ready; pop when out_valid && out_ready. Both may occur in the same cycle; count is unchanged.
- Opcode decode, using in_ins[6:0]; in_ins[1:0] != 2'b11 means illegal:
  - I: 0000011, 0001111, 0010011, 1100111, 1110011; also 0011011 when XLEN=64.
  - S: 0100011. B: 1100011. U: 0010111 (AUIPC), 0110111 (LUI). J: 1101111.
  - R-type (0110011; also 0111011 when XLEN=64): fmt 0, imm 0, target 0, illegal 0.
  - Any other opcode: fmt 0, imm 0, target 0, illegal 1.
- Immediates are sign-extended from in_ins[31] to XLEN:
  - I = ins[31:20].
  - S = {ins[31:25], ins[11:7]}.
  - B = {ins[31], ins[7], ins[30:25], ins[11:8], 0}.
  - U = {ins[31:12], 12'b0}, sign-extended above bit 31 when XLEN=64.
  - J = {ins[31], ins[19:12], ins[20], ins[30:21], 0}.
- Target = in_pc + imm, modulo 2^XLEN (wraps silently), only for B, J and AUIPC. JALR target is 0 because rs1 is not known here.
- Decode and add happen before the FIFO write; the FIFO stores {imm, fmt, target, illegal}.
- flush has priority over push and pop: count goes to 0, and any push in the same cycle is dropped.
- All data outputs are forced to 0 whenever out_valid = 0.

## Timing
- Reset (rst_n=0 at an edge): count=0, pointers=0, out_valid=0, in_ready=1, all data outputs 0. Reset mid-stream discards all entries.
- Latency: an instruction accepted at edge N appears on the outputs with out_valid=1 after edge N (1 cycle).
- in_ready is a function of registered count only. There is no combinational path from out_ready.
  - When full, a simultaneous pop does not allow a push that cycle; in_ready rises the cycle after the pop.
- Throughput: 1 instruction per cycle while out_ready=1.
- Empty: out_valid=0, and out_ready is ignored.
- Full: in_ready=0, and in_valid is ignored.
- Pointers wrap modulo DEPTH.
- out_* stay stable while out_valid=1 and out_ready=0.

## Test plan
- XLEN=32, in_pc=0x100:
  - 0x00500093 -> fmt=I, imm=0x00000005, target=0.
  - 0xFE000EE3 -> fmt=B, imm=0xFFFFFFFC, target=0x000000FC.
- XLEN=32: 0x0080006F at pc=0xFFFFFFFC -> fmt=J, imm=8, target=0x00000004 (wrap).
- XLEN=64:
  - 0x80000037 -> fmt=U, imm=0xFFFFFFFF80000000.
  - 0x0000003B -> fmt=0, illegal=0.
- 0x00000000 and 0x0000007F -> illegal=1, fmt=0, imm=0, target=0.
- DEPTH=2, out_ready=0, in_valid held for 4 cycles:
  - 2 pushes accepted, then in_ready=0.
  - Raise out_ready -> outputs drain in order, 1 per cycle.
  - in_ready returns 1 the cycle after the first pop.
- Flush and reset:
  - Fill 1 entry, assert flush together with a push -> next cycle out_valid=0, count=0.
  - Assert rst_n=0 while full -> next cycle out_valid=0, in_ready=1, outputs 0.
